// File: rtl/bit_serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default datapath
// width and the control FSM state encoding.
package bit_serial_addsub_pkg;

    // Default datapath width of the core.
    localparam int XLEN = 32;

    // Width of the FSM state register.
    localparam int STATE_W = 2;

    // Control FSM states.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : bit_serial_addsub_pkg

// File: rtl/bit_serial_addsub_fa_cell.sv
// Purely combinational single-bit full adder, iterated LSB-first by the
// bit-serial adder/subtractor.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : fa_cell

// File: rtl/bit_serial_addsub.sv
// Multi-cycle bit-serial adder/subtractor. Operands arrive on a valid/ready
// handshake, one bit per clock is added LSB-first with a registered carry,
// and the result plus ALU flags leave on a second valid/ready handshake.
module bit_serial_addsub
    import bit_serial_addsub_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    // Counter value seen on the edge that processes the MSB.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] shift_a_r;
    logic [WIDTH-1:0] shift_b_r;
    logic [WIDTH-1:0] result_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             out_valid_r;

    logic             sum_s;
    logic             cout_s;
    logic             last_bit_s;
    logic [WIDTH-1:0] result_next_s;

    // The single full-adder cell works on the current LSBs and the stored carry.
    fa_cell u_fa_cell (
        .a    (shift_a_r[0]),
        .b    (shift_b_r[0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Next shifted result and end-of-operation detection for the RUN state.
    always_comb begin
        result_next_s = {sum_s, result_r[WIDTH-1:1]};
        if (cnt_r == CNT_LAST) begin
            last_bit_s = 1'b1;
        end else begin
            last_bit_s = 1'b0;
        end
    end

    // Operands are accepted only in IDLE; ready drops during the reset cycle.
    assign in_ready = (state_r == IDLE) && !rst;

    // Control FSM together with the shift registers, counter, carry and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_a_r   <= {WIDTH{1'b0}};
            shift_b_r   <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
                        shift_a_r <= op_a;
                        shift_b_r <= sub ? ~op_b : op_b;
                        carry_r   <= sub;
                        cnt_r     <= {CNT_W{1'b0}};
                        state_r   <= RUN;
                    end
                end
                RUN: begin
                    shift_a_r <= {1'b0, shift_a_r[WIDTH-1:1]};
                    shift_b_r <= {1'b0, shift_b_r[WIDTH-1:1]};
                    result_r  <= result_next_s;
                    carry_r   <= cout_s;
                    cnt_r     <= cnt_r + CNT_W'(1'b1);
                    if (last_bit_s) begin
                        // carry_r still holds the carry into the MSB at this edge.
                        carry_out_r <= cout_s;
                        overflow_r  <= carry_r ^ cout_s;
                        zero_r      <= (result_next_s == {WIDTH{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule : bit_serial_addsub
